// File: rtl/shaft_model_pkg.sv
// rtl/shaft_model_pkg.sv - shared motor command encodings and shaft constants
package shaft_model_pkg;

  // Motor command encodings as seen on the motor input
  typedef enum logic [1:0] {
    MOTOR_STOP    = 2'b00,
    MOTOR_UP      = 2'b01,
    MOTOR_DOWN    = 2'b10,
    MOTOR_ILLEGAL = 2'b11
  } motor_cmd_e;

  // Number of floors served by the shaft
  localparam int NUM_FLOORS = 4;

endpackage

// File: rtl/shaft_floor_dec.sv
// rtl/shaft_floor_dec.sv - combinational map from car position to floor sensor and floor number
module shaft_floor_dec
  import shaft_model_pkg::*;
#(
  parameter int STEP = 8,
  parameter int PW   = 5
) (
  input  logic [PW-1:0] pos,
  output logic [3:0]    floor_sens,
  output logic [2:0]    floor_num
);

  // A floor is sensed only when the car sits exactly on its landing position
  always_comb begin
    floor_sens = '0;
    floor_num  = '0;
    for (int k = 0; k < NUM_FLOORS; k++) begin
      if (pos == PW'(k * STEP)) begin
        floor_sens[k] = 1'b1;
        floor_num     = 3'(k + 1);
      end
    end
  end

endmodule

// File: rtl/shaft_model.sv
// rtl/shaft_model.sv - elevator shaft model: prescaled car position, floor sensors, door timer, faults (optional door: SHAFT_DOOR_EN)
module shaft_model
  import shaft_model_pkg::*;
#(
  parameter int DIV         = 4,
  parameter int STEP        = 8,
  parameter int DOOR_CYCLES = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] motor,
  output logic [3:0] floor_sens,
  output logic [2:0] floor_num,
  output logic       door_open,
  output logic       limit_fault,
  output logic       cmd_fault
);

  localparam int TOP_POS = (NUM_FLOORS - 1) * STEP;
  localparam int PW      = $clog2(TOP_POS + 1);
  localparam int CW      = $clog2(DIV);
  localparam logic [PW-1:0] POS_TOP  = PW'(TOP_POS);
  localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 1);

  motor_cmd_e cmd;
  logic       want_up;
  logic       want_dn;
  logic       limit_hit;
  logic       door_block;
  logic       move_en;

  logic [PW-1:0] pos_q, pos_d;
  logic [CW-1:0] pre_q, pre_d;
  logic [3:0]    floor_sens_q, floor_sens_d;
  logic [2:0]    floor_num_q, floor_num_d;
  logic          limit_fault_q, limit_fault_d;
  logic          cmd_fault_q, cmd_fault_d;

  assign cmd     = motor_cmd_e'(motor);
  assign want_up = (cmd == MOTOR_UP);
  assign want_dn = (cmd == MOTOR_DOWN);

  // A move toward a shaft end the car already occupies is refused
  assign limit_hit = (want_up && (pos_q == POS_TOP)) ||
                     (want_dn && (pos_q == '0));
  assign move_en   = (want_up || want_dn) && !door_block && !limit_hit;

  // Prescaler runs only while moving; pos steps once per DIV enabled cycles
  always_comb begin
    pos_d         = pos_q;
    pre_d         = '0;
    limit_fault_d = limit_hit;
    cmd_fault_d   = (cmd == MOTOR_ILLEGAL);
    if (move_en) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        pos_d = want_up ? (pos_q + 1'b1) : (pos_q - 1'b1);
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // Decoding the next position keeps the registered sensors aligned with pos
  shaft_floor_dec #(
    .STEP (STEP),
    .PW   (PW)
  ) u_floor_dec (
    .pos        (pos_d),
    .floor_sens (floor_sens_d),
    .floor_num  (floor_num_d)
  );

  // Position, prescaler and registered outputs; reset parks the car at floor 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q         <= '0;
      pre_q         <= '0;
      floor_sens_q  <= 4'b0001;
      floor_num_q   <= 3'd1;
      limit_fault_q <= 1'b0;
      cmd_fault_q   <= 1'b0;
    end else begin
      pos_q         <= pos_d;
      pre_q         <= pre_d;
      floor_sens_q  <= floor_sens_d;
      floor_num_q   <= floor_num_d;
      limit_fault_q <= limit_fault_d;
      cmd_fault_q   <= cmd_fault_d;
    end
  end

`ifdef SHAFT_DOOR_EN
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES);

  logic [DW-1:0] door_cnt_q, door_cnt_d;
  logic          door_open_q, door_open_d;
  logic          at_floor;

  assign at_floor   = (floor_num_q != 3'd0);
  assign door_block = door_open_q;

  // Door timer counts stopped cycles at a landing; any move command closes the door
  always_comb begin
    door_cnt_d  = '0;
    door_open_d = door_open_q;
    if ((cmd == MOTOR_STOP) && at_floor) begin
      door_cnt_d = (door_cnt_q == DOOR_LAST) ? door_cnt_q : (door_cnt_q + 1'b1);
      if (door_cnt_d == DOOR_LAST) begin
        door_open_d = 1'b1;
      end
    end
    if (want_up || want_dn) begin
      door_open_d = 1'b0;
    end
  end

  // Door counter and door state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      door_cnt_q  <= '0;
      door_open_q <= 1'b0;
    end else begin
      door_cnt_q  <= door_cnt_d;
      door_open_q <= door_open_d;
    end
  end

  assign door_open = door_open_q;
`else
  // No door hardware: the door never blocks motion and always reads closed.
  // DOOR_CYCLES stays in the interface so both builds share one parameter list.
  assign door_block = 1'b0;
  assign door_open  = (DOOR_CYCLES < 0);
`endif

  assign floor_sens  = floor_sens_q;
  assign floor_num   = floor_num_q;
  assign limit_fault = limit_fault_q;
  assign cmd_fault   = cmd_fault_q;

endmodule

// File: tb/tb_shaft_model.sv
// tb/tb_shaft_model.sv - randomized self-checking bench for shaft_model against a behavioural car model
module tb_shaft_model;

  localparam int DIV     = 4;
  localparam int STEP    = 8;
  localparam int DOOR    = 12;
  localparam int TOP_POS = 3 * STEP;

  logic       clk;
  logic       rst;
  logic [1:0] motor;
  logic [3:0] floor_sens;
  logic [2:0] floor_num;
  logic       door_open;
  logic       limit_fault;
  logic       cmd_fault;

  int errors;
  int checks;

  // Behavioural car state
  int m_pos;
  int m_phase;
  int m_cnt;
  int m_door;
  int m_lim;
  int m_cmd;

  shaft_model #(
    .DIV         (DIV),
    .STEP        (STEP),
    .DOOR_CYCLES (DOOR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .motor       (motor),
    .floor_sens  (floor_sens),
    .floor_num   (floor_num),
    .door_open   (door_open),
    .limit_fault (limit_fault),
    .cmd_fault   (cmd_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_floor();
    if (m_pos % STEP == 0) return m_pos / STEP + 1;
    return 0;
  endfunction

  function automatic int exp_sens();
    int f;
    f = exp_floor();
    if (f == 0) return 0;
    return 1 << (f - 1);
  endfunction

  task automatic model_reset();
    m_pos   = 0;
    m_phase = 0;
    m_cnt   = 0;
    m_door  = 0;
    m_lim   = 0;
    m_cmd   = 0;
  endtask

  // One clock edge of the car as described in plain terms
  task automatic model_edge(input int m);
    int up;
    int dn;
    int lim;
    int moving;
    int was_at_floor;
    up           = (m == 1);
    dn           = (m == 2);
    lim          = (up && m_pos == TOP_POS) || (dn && m_pos == 0);
    was_at_floor = (m_pos % STEP == 0);
`ifdef SHAFT_DOOR_EN
    moving = (up || dn) && !m_door && !lim;
`else
    moving = (up || dn) && !lim;
`endif
    if (moving) begin
      m_phase++;
      if (m_phase == DIV) begin
        m_pos   = up ? m_pos + 1 : m_pos - 1;
        m_phase = 0;
      end
    end else begin
      m_phase = 0;
    end
    m_lim = lim;
    m_cmd = (m == 3);
`ifdef SHAFT_DOOR_EN
    if (m == 0 && was_at_floor) begin
      if (m_cnt < DOOR) m_cnt++;
      if (m_cnt == DOOR) m_door = 1;
    end else begin
      m_cnt = 0;
    end
    if (up || dn) m_door = 0;
`else
    if (was_at_floor) m_cnt = 0;
`endif
  endtask

  task automatic compare_all();
    check("floor_sens", int'(floor_sens), exp_sens());
    check("floor_num", int'(floor_num), exp_floor());
    check("door_open", int'(door_open), m_door);
    check("limit_fault", int'(limit_fault), m_lim);
    check("cmd_fault", int'(cmd_fault), m_cmd);
  endtask

  // Apply a command for one edge, advance the model and compare after the edge
  task automatic step(input int m);
    motor = 2'(m);
    @(posedge clk);
    model_edge(m);
    #1;
    compare_all();
  endtask

  initial begin
    int cmd;
    int len;
    int r;
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    motor  = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_sens", int'(floor_sens), 1);
    check("reset_num", int'(floor_num), 1);
    check("reset_door", int'(door_open), 0);
    check("reset_lim", int'(limit_fault), 0);
    check("reset_cmd", int'(cmd_fault), 0);
    rst = 1'b0;

    // Climb from floor 1 to floor 2 with the default geometry
    for (int e = 1; e <= 32; e++) begin
      step(1);
      if (e == 3)  check("climb_e3_sens", int'(floor_sens), 4'b0001);
      if (e == 4)  check("climb_e4_sens", int'(floor_sens), 4'b0000);
      if (e == 31) check("climb_e31_sens", int'(floor_sens), 4'b0000);
      if (e == 32) begin
        check("climb_e32_sens", int'(floor_sens), 4'b0010);
        check("climb_e32_num", int'(floor_num), 2);
      end
    end

    // Continue to the top and push against the upper limit
    for (int e = 1; e <= 70; e++) step(1);
    check("top_sens", int'(floor_sens), 4'b1000);
    check("top_limit", int'(limit_fault), 1);

    // Illegal command at the top landing
    for (int e = 1; e <= 3; e++) begin
      step(3);
      check("illegal_pulse", int'(cmd_fault), 1);
    end
    check("illegal_hold_num", int'(floor_num), 4);

    // Randomized bursts of held commands
    for (int b = 0; b < 70; b++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      cmd = 1;
      else if (r < 7) cmd = 2;
      else if (r < 9) cmd = 0;
      else            cmd = 3;
      len = int'($urandom_range(1, 40));
      for (int i = 0; i < len; i++) step(cmd);

      // Occasionally reset mid-burst, away from any clock edge
      if (b % 23 == 22) begin
        motor = 2'b10;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sens", int'(floor_sens), 1);
        check("async_rst_num", int'(floor_num), 1);
        check("async_rst_door", int'(door_open), 0);
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
